// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam logic [7:0] EOL_DEFAULT = 8'h0A;

    // Source slots as wired in fpga_top.
    localparam logic [1:0] SRC_CPU = 2'd0;
    localparam logic [1:0] SRC_MON = 2'd1;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first set request after i_last, wrapping modulo N.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [1:0]   i_last,
    output logic [1:0]   o_idx,
    output logic         o_any
);

    logic [3:0] w_req;
    logic [2:0] w_pos;
    logic       w_found;

    assign w_req = 4'(i_req);
    assign o_any = |i_req;

    always_comb begin
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= N; k++) begin
            // i_last < N and k <= N, so one subtraction is enough to wrap.
            w_pos = {1'b0, i_last} + 3'(k);
            if (w_pos >= 3'(N))
                w_pos = w_pos - 3'(N);
            if (!w_found && w_req[w_pos[1:0]]) begin
                o_idx   = w_pos[1:0];
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin line-locked arbiter sharing one UART tx serializer between N_REQ byte sources.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int         N_REQ     = 2,
    parameter logic [7:0] EOL_CHAR  = EOL_DEFAULT,
    parameter int         TIMEOUT   = 1024,
    parameter int         MAX_BURST = 256,
    parameter int         CNT_W     = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    output logic [1:0]         grant_id,
    output logic               busy
);

    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       r_state, w_state_nxt;
    logic [1:0]       r_grant, r_last;
    logic [CNT_W-1:0] r_idle, r_burst;
    logic             r_tx_valid;
    logic [7:0]       r_tx_data;

    logic       w_gvalid;
    logic [7:0] w_gdata;
    logic       w_slot_free, w_accept, w_release;
    logic [1:0] w_win;
    logic       w_any;

    rr_pick #(.N(N_REQ)) u_pick (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_idx  (w_win),
        .o_any  (w_any)
    );

    always_comb begin
        w_gvalid = 1'b0;
        w_gdata  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant == 2'(i)) begin
                w_gvalid = req_valid[i];
                w_gdata  = req_data[8*i +: 8];
            end
        end
    end

    // The output register can take a byte when empty or draining this cycle.
    assign w_slot_free = !r_tx_valid || tx_ready;

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any)
                    w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                for (int i = 0; i < N_REQ; i++)
                    if (r_grant == 2'(i))
                        req_ready[i] = w_slot_free;
                w_accept  = w_gvalid && w_slot_free;
                w_release = (w_accept && ((w_gdata == EOL_CHAR) || (r_burst == BURST_LAST)))
                         || (!w_gvalid && (r_idle == IDLE_LAST));
                if (w_release)
                    w_state_nxt = ST_IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= SRC_CPU;
            r_last  <= 2'(N_REQ - 1);
            r_idle  <= '0;
            r_burst <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_any) begin
                r_grant <= w_win;
                r_idle  <= '0;
                r_burst <= '0;
            end
        end else begin
            if (w_release)
                r_last <= r_grant;
            if (w_gvalid)
                r_idle <= '0;
            else if (r_idle != '1)
                r_idle <= r_idle + 1'b1;
            if (w_accept && (r_burst != '1))
                r_burst <= r_burst + 1'b1;
        end
    end

    // Drains regardless of arbiter state; a pending byte is dropped only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else if (w_accept) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_gdata;
        end else if (tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign grant_id = r_grant;
    assign busy     = (r_state == ST_LOCKED);

endmodule
